// File: rtl/ctrl_arbiter_pkg.sv
// Shared definitions for the emulator control-port arbiter: FSM encodings
// and the supported requester count.
package ctrl_arbiter_pkg;

  localparam int N_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/ctrl_rr_pick.sv
// Combinational N-way round-robin picker: the first set request at or after
// ptr (wrapping mod N) wins.
module ctrl_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic found_s;

  // Scan outward from ptr and keep only the first hit.
  always_comb begin
    int idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found_s && req[idx]) begin
        found_s     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = PTR_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // A grant exists whenever anyone is asking.
  always_comb begin
    any = |req;
  end

endmodule

// File: rtl/ctrl_arbiter.sv
// Round-robin, non-preemptive arbiter sharing the emulator control register
// port between N requesters; one access in flight at a time.
module ctrl_arbiter
  import ctrl_arbiter_pkg::*;
#(
  parameter int N      = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                host_clk,
  input  logic                host_rst,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [N-1:0]        req_write,
  input  logic [N*ADDR_W-1:0] req_addr,
  input  logic [N*DATA_W-1:0] req_wdata,
  output logic [N-1:0]        resp_valid,
  input  logic [N-1:0]        resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                ctrl_wen,
  output logic [ADDR_W-1:0]   ctrl_waddr,
  output logic [DATA_W-1:0]   ctrl_wdata,
  output logic                ctrl_ren,
  output logic [ADDR_W-1:0]   ctrl_raddr,
  input  logic [DATA_W-1:0]   ctrl_rdata
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_r, state_nxt_s;
  logic [PTR_W-1:0]   ptr_r, gnt_r, pick_idx_s;
  logic [N-1:0]       pick_oh_s;
  logic               pick_any_s;
  logic               accept_s;
  logic               resp_done_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r, rdata_r;
  logic               wr_r;

  ctrl_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_r),
    .gnt_oh  (pick_oh_s),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // Handshake qualifiers; only the granted requester's resp_ready matters.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && pick_any_s;
    resp_done_s = (state_r == ST_RESP) && resp_ready[gnt_r];
  end

  // State register.
  always_ff @(posedge host_clk or posedge host_rst) begin
    if (host_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = pick_any_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt_s = ST_RESP;
      ST_RESP:  state_nxt_s = resp_done_s ? ST_IDLE : ST_RESP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant, pointer and payload capture; read data is taken during the strobe.
  always_ff @(posedge host_clk or posedge host_rst) begin
    if (host_rst) begin
      ptr_r   <= '0;
      gnt_r   <= '0;
      wr_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else if (accept_s) begin
      gnt_r   <= pick_idx_s;
      wr_r    <= req_write[pick_idx_s];
      addr_r  <= req_addr[pick_idx_s*ADDR_W +: ADDR_W];
      wdata_r <= req_wdata[pick_idx_s*DATA_W +: DATA_W];
      ptr_r   <= (pick_idx_s == PTR_W'(N - 1)) ? PTR_W'(0) : pick_idx_s + PTR_W'(1);
    end else if ((state_r == ST_ISSUE) && !wr_r) begin
      rdata_r <= ctrl_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Output decode; req_ready is held low while reset is asserted.
  always_comb begin
    req_ready  = (accept_s && !host_rst) ? pick_oh_s : '0;
    ctrl_wen   = (state_r == ST_ISSUE) && wr_r;
    ctrl_ren   = (state_r == ST_ISSUE) && !wr_r;
    ctrl_waddr = addr_r;
    ctrl_raddr = addr_r;
    ctrl_wdata = wdata_r;
    resp_rdata = rdata_r;
    for (int i = 0; i < N; i++) begin
      resp_valid[i] = (state_r == ST_RESP) && (gnt_r == PTR_W'(i));
    end
  end

endmodule
